// File: rtl/garage_pkg.sv
// Shared types and defaults for the garage motor arbiter.
// The GARAGE_ARB_TIMEOUT_EN build option is consumed by garage_motor_arbiter.
package garage_pkg;

  typedef enum logic [1:0] {
    STOP = 2'b00,
    UP   = 2'b10,
    DOWN = 2'b11
  } motor_ctrl_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    COOLDOWN
  } arb_state_t;

  localparam int DEF_TIMEOUT_CYCLES  = 1000;
  localparam int DEF_COOLDOWN_CYCLES = 16;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Sized to hold the longer of the two phases, since one counter serves both.
  function automatic int cnt_width(input int t, input int c);
    return $clog2(((t > c) ? t : c) + 1);
  endfunction

endpackage

// File: rtl/garage_rr_pick.sv
// Combinational round-robin picker: the search starts at the entry after ptr,
// so the last owner has lowest priority.
module garage_rr_pick #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [SW-1:0] ptr,
  output logic          valid,
  output logic [SW-1:0] idx
);

  function automatic logic [SW-1:0] wrap_idx(input logic [SW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return SW'(s);
  endfunction

  // Walk offsets from farthest to nearest so the nearest eligible entry wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N; k >= 1; k--) begin
      if (elig[wrap_idx(ptr, k)]) begin
        valid = 1'b1;
        idx   = wrap_idx(ptr, k);
      end
    end
  end

endmodule

// File: rtl/garage_motor_arbiter.sv
// Round-robin owner of one shared garage-door motor, with mandatory cool-down.
// Define GARAGE_ARB_TIMEOUT_EN to build in the travel watchdog and sticky faults.
module garage_motor_arbiter
  import garage_pkg::*;
#(
  parameter int N_DOORS         = 4,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  localparam int SW             = sel_width(N_DOORS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*N_DOORS-1:0] cmd,
  input  logic [N_DOORS-1:0]   done,
  input  logic [N_DOORS-1:0]   fault_clr,
  output logic [N_DOORS-1:0]   grant,
  output logic [SW-1:0]        sel,
  output logic [1:0]           motor_ctrl,
  output logic                 busy,
  output logic [N_DOORS-1:0]   fault
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES, COOLDOWN_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CD_LAST = CW'(COOLDOWN_CYCLES - 1);
`ifdef GARAGE_ARB_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif

  arb_state_t         state, state_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic [SW-1:0]      ptr, ptr_d, sel_d;
  motor_ctrl_t        lcmd, lcmd_d, motor, motor_d;
  logic [N_DOORS-1:0] grant_d, fault_q, elig;
  logic               busy_d;
  logic [1:0]         cmd_arr [N_DOORS];
  logic               pick_valid;
  logic [SW-1:0]      pick_idx;
  logic               owner_stop, timeout_hit;
`ifdef GARAGE_ARB_TIMEOUT_EN
  logic [N_DOORS-1:0] fault_set;
`endif

  // Only bit 1 distinguishes a travel request; 01 behaves as stop.
  always_comb begin
    for (int i = 0; i < N_DOORS; i++) begin
      cmd_arr[i] = cmd[2*i +: 2];
      elig[i]    = cmd[2*i+1] & ~fault_q[i];
    end
  end

  garage_rr_pick #(.N(N_DOORS), .SW(SW)) u_pick (
    .elig  (elig),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    ptr_d       = ptr;
    sel_d       = sel;
    lcmd_d      = lcmd;
    grant_d     = grant;
    motor_d     = motor;
    busy_d      = busy;
    owner_stop  = done[sel] | (cmd_arr[sel] != lcmd);
    timeout_hit = 1'b0;
`ifdef GARAGE_ARB_TIMEOUT_EN
    fault_set   = '0;
    timeout_hit = (cnt == TO_LAST);
`endif
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_d = RUN;
          cnt_d   = '0;
          ptr_d   = pick_idx;
          sel_d   = pick_idx;
          lcmd_d  = motor_ctrl_t'(cmd_arr[pick_idx]);
          motor_d = motor_ctrl_t'(cmd_arr[pick_idx]);
          grant_d = N_DOORS'(1) << pick_idx;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        // A done or cmd change in the same cycle as the watchdog suppresses the fault.
        if (owner_stop || timeout_hit) begin
          state_d = COOLDOWN;
          cnt_d   = '0;
          grant_d = '0;
          motor_d = STOP;
`ifdef GARAGE_ARB_TIMEOUT_EN
          if (!owner_stop) fault_set[sel] = 1'b1;
        end else begin
          cnt_d = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
`endif
        end
      end
      COOLDOWN: begin
        if (cnt == CD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer resets to the last door so door 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= SW'(N_DOORS - 1);
      sel   <= '0;
      lcmd  <= STOP;
      grant <= '0;
      motor <= STOP;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      ptr   <= ptr_d;
      sel   <= sel_d;
      lcmd  <= lcmd_d;
      grant <= grant_d;
      motor <= motor_d;
      busy  <= busy_d;
    end
  end

`ifdef GARAGE_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= '0;
    else        fault_q <= (fault_q & ~fault_clr) | fault_set;
  end
`else
  logic unused_fault_clr;
  assign unused_fault_clr = ^fault_clr;
  assign fault_q = '0;
`endif

  assign motor_ctrl = motor;
  assign fault      = fault_q;

endmodule

// File: tb/tb_garage_motor_arbiter.sv
// Directed self-checking bench for garage_motor_arbiter (4 doors, default timing).
// Watchdog/fault checks are compiled in when GARAGE_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_garage_motor_arbiter;

  localparam int N   = 4;
  localparam int TMO = 1000;
  localparam int CD  = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [2*N-1:0] cmd;
  logic [N-1:0]   done, fault_clr, grant, fault;
  logic [1:0]     sel, motor_ctrl;
  logic           busy;
  int             nCompared = 0;
  int             nMismatched = 0;

  always #5 clk = ~clk;

  garage_motor_arbiter #(.N_DOORS(N), .TIMEOUT_CYCLES(TMO), .COOLDOWN_CYCLES(CD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd),
    .done       (done),
    .fault_clr  (fault_clr),
    .grant      (grant),
    .sel        (sel),
    .motor_ctrl (motor_ctrl),
    .busy       (busy),
    .fault      (fault)
  );

  typedef struct {
    logic [N-1:0] reqMask;
    logic [1:0]   reqCmd;
    int           runLen;
    logic [N-1:0] expGrant;
    logic [1:0]   expSel;
    logic [1:0]   expMotor;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [N-1:0] mask, input logic [1:0] c);
    for (int i = 0; i < N; i++) cmd[2*i +: 2] = mask[i] ? c : 2'b00;
  endtask

  task automatic waitGrant(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (grant == '0 && n < 60);
    checkOutput(name, {31'd0, grant != '0}, 32'd1);
  endtask

  // Called on the first negedge after the exit edge; ends on the IDLE cycle.
  task automatic checkCooldown(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    checkOutput({name, "_cd_len"}, n, CD);
    checkOutput({name, "_idle_grant"}, grant, 0);
    checkOutput({name, "_idle_motor"}, motor_ctrl, 0);
  endtask

  task automatic finishTravel(input string name, input int door);
    done[door] = 1'b1;
    tick();
    done = '0;
    checkOutput({name, "_stop_motor"}, motor_ctrl, 0);
    checkOutput({name, "_stop_grant"}, grant, 0);
    checkOutput({name, "_stop_busy"}, busy, 1);
    checkCooldown(name);
  endtask

  initial begin
    int cnt;
    logic seen;

    vecs[0] = '{4'b1011, 2'b10, 5, 4'b0001, 2'd0, 2'b10};
    vecs[1] = '{4'b1011, 2'b10, 5, 4'b0010, 2'd1, 2'b10};
    vecs[2] = '{4'b1011, 2'b10, 5, 4'b1000, 2'd3, 2'b10};
    vecs[3] = '{4'b1011, 2'b10, 5, 4'b0001, 2'd0, 2'b10};
    vecs[4] = '{4'b0100, 2'b11, 3, 4'b0100, 2'd2, 2'b11};
    vecs[5] = '{4'b1001, 2'b10, 1, 4'b1000, 2'd3, 2'b10};
    vecs[6] = '{4'b0110, 2'b11, 2, 4'b0010, 2'd1, 2'b11};
    vecs[7] = '{4'b1111, 2'b10, 4, 4'b0100, 2'd2, 2'b10};

    rst_n = 1'b0;
    cmd = '0;
    done = '0;
    fault_clr = '0;
    repeat (2) tick();
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_sel", sel, 0);
    checkOutput("rst_motor", motor_ctrl, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_fault", fault, 0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].reqMask, vecs[v].reqCmd);
      waitGrant($sformatf("v%0d_wait", v));
      checkOutput($sformatf("v%0d_grant", v), grant, vecs[v].expGrant);
      checkOutput($sformatf("v%0d_sel", v), sel, vecs[v].expSel);
      checkOutput($sformatf("v%0d_motor", v), motor_ctrl, vecs[v].expMotor);
      checkOutput($sformatf("v%0d_busy", v), busy, 1);
      repeat (vecs[v].runLen - 1) tick();
      checkOutput($sformatf("v%0d_hold", v), motor_ctrl, vecs[v].expMotor);
      finishTravel($sformatf("v%0d", v), int'(vecs[v].expSel));
    end

    // 01 is not a request.
    applyStimulus(4'b0001, 2'b01);
    repeat (5) tick();
    checkOutput("cmd01_grant", grant, 0);
    checkOutput("cmd01_busy", busy, 0);

    // Non-owner inputs are ignored; owner reversal ends the travel.
    applyStimulus(4'b0010, 2'b10);
    waitGrant("rev_wait");
    checkOutput("rev_sel", sel, 1);
    done = 4'b1101;
    cmd[1:0] = 2'b11;
    repeat (2) tick();
    checkOutput("rev_ignore_motor", motor_ctrl, 2'b10);
    checkOutput("rev_ignore_grant", grant, 4'b0010);
    done = '0;
    cmd[1:0] = 2'b00;
    cmd[3:2] = 2'b11;
    tick();
    checkOutput("rev_stop_motor", motor_ctrl, 0);
    checkOutput("rev_stop_grant", grant, 0);
    checkCooldown("rev");
    tick();
    checkOutput("rev_regrant", grant, 4'b0010);
    checkOutput("rev_regrant_motor", motor_ctrl, 2'b11);
    finishTravel("rev_end", 1);

    // Asynchronous reset mid-travel, then the pointer restarts at door 0.
    applyStimulus(4'b0010, 2'b10);
    waitGrant("arst_wait");
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_motor", motor_ctrl, 0);
    checkOutput("arst_grant", grant, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_sel", sel, 0);
    tick();
    rst_n = 1'b1;
    applyStimulus(4'b1111, 2'b10);
    waitGrant("arst_rr_wait");
    checkOutput("arst_rr_sel", sel, 0);
    finishTravel("arst_end", 0);

`ifdef GARAGE_ARB_TIMEOUT_EN
    applyStimulus(4'b1000, 2'b11);
    waitGrant("tmo_wait");
    cnt = 0;
    while (motor_ctrl == 2'b11 && cnt < TMO + 100) begin
      cnt++;
      tick();
    end
    checkOutput("tmo_run_len", cnt, TMO);
    checkOutput("tmo_fault", fault, 4'b1000);
    checkCooldown("tmo");
    seen = 1'b0;
    repeat (30) begin
      tick();
      seen = seen | (grant != '0);
    end
    checkOutput("tmo_skip", {31'd0, seen}, 0);
    fault_clr = 4'b1000;
    tick();
    fault_clr = '0;
    checkOutput("tmo_clr", fault, 0);
    waitGrant("tmo_regrant_wait");
    checkOutput("tmo_regrant_sel", sel, 3);
    repeat (TMO - 1) tick();
    done[3] = 1'b1;
    tick();
    done = '0;
    checkOutput("tmo_done_tie_motor", motor_ctrl, 0);
    checkOutput("tmo_done_tie_fault", fault, 0);
    checkCooldown("tmo_tie");
`else
    applyStimulus(4'b0001, 2'b10);
    waitGrant("notmo_wait");
    cnt = 0;
    seen = 1'b0;
    repeat (2000) begin
      tick();
      if (motor_ctrl == 2'b10) cnt++;
      seen = seen | (fault != '0);
    end
    checkOutput("notmo_run", cnt, 2000);
    checkOutput("notmo_fault", {31'd0, seen}, 0);
    finishTravel("notmo_end", 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=stalled required=finished");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule

// File: doc/garage_motor_arbiter.md
# garage_motor_arbiter

Shares one reversible garage-door motor drive between `N_DOORS` door controllers, granting it to one door at a time in round-robin order. Each door controller presents its 2-bit motor command and a travel-complete indication; the arbiter latches the winning command, drives the shared motor, and runs the travel to completion or timeout. Every travel ends with a mandatory cool-down before the drive is granted again. It sits between the per-door FSMs and the motor driver.

## Interface
- `N_DOORS`, 4: number of requesting door controllers, 2..8.
- `TIMEOUT_CYCLES`, 1000: maximum RUN cycles per travel.
- `COOLDOWN_CYCLES`, 16: idle motor cycles after every travel, ≥1.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd`  in  N_DOORS×2  per-door command: 00 stop, 10 up/open, 11 down/close. 01 is treated as 00.
- `done`  in  N_DOORS  per-door limit sensor: travel complete.
- `fault_clr`  in  N_DOORS  per-door single-cycle clear of the sticky fault.
- `grant`  out  N_DOORS  one-hot owner of the motor; all zero when no owner.
- `sel`  out  max(1,$clog2(N_DOORS))  index of the current or last owner.
- `motor_ctrl`  out  2  shared motor drive, same encoding as `cmd`.
- `busy`  out  1  high in RUN and COOLDOWN.
- `fault`  out  N_DOORS  sticky timeout flag per door.

## Operation
- All outputs are registered. Reset values: `grant`=0, `sel`=0, `motor_ctrl`=00, `busy`=0, `fault`=0. The round-robin pointer resets so door 0 has highest priority. State resets to IDLE.
- **IDLE**
  - A door is eligible when `cmd`≠00/01 and its `fault` is 0.
  - The pick is round-robin, starting at the index after the last owner.
  - On a pick, the arbiter latches `cmd` and sets `grant`, `sel`, `motor_ctrl`=latched cmd, `busy`=1. The pointer updates to the owner. Next state is RUN.
  - No eligible door: stay in IDLE.
- **RUN**
  - `motor_ctrl` holds the latched cmd. The cycle counter starts at 0 on entry.
  - Exit to COOLDOWN on the first of the following conditions:
    - `done[sel]`=1.
    - `cmd[sel]` goes to stop, or to any value other than the latched cmd (reversal).
    - Counter reaches `TIMEOUT_CYCLES`-1 without any of the above. This also sets `fault[sel]`.
  - If `done` and timeout occur in the same cycle, `done` wins and no fault is set.
  - Inputs from non-owners are ignored.
- **COOLDOWN**
  - `grant`=0 and `motor_ctrl`=00 for exactly `COOLDOWN_CYCLES` cycles, with `busy`=1.
  - Then the arbiter returns to IDLE with `busy`=0.
  - A reversal request is therefore re-arbitrated only after cool-down.
- **Fault flags**
  - `fault_clr[i]` clears `fault[i]` on the next edge.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - A faulted door is never granted.
- `rst_n` low mid-travel drops `motor_ctrl` to 00 asynchronously, with no cool-down.

## Timing
- Request seen in IDLE on edge t → `grant` and `motor_ctrl` valid after edge t+1.
- Exit condition sampled on edge k in RUN → `motor_ctrl`=00 after edge k+1.
- A travel drives the motor at most `TIMEOUT_CYCLES` cycles.
- Minimum gap between two grants is `COOLDOWN_CYCLES`+1 cycles, including one IDLE cycle.
- Counter width is $clog2(max(TIMEOUT_CYCLES,COOLDOWN_CYCLES)+1). The counter is shared between RUN and COOLDOWN and saturates; it never wraps.

## Configuration
- `GARAGE_ARB_TIMEOUT_EN` defined:
  - The travel watchdog and the `fault` logic are present, as described above.
- `GARAGE_ARB_TIMEOUT_EN` undefined:
  - RUN ends only on `done` or a `cmd` change.
  - `fault` is tied to 0 and `fault_clr` is ignored.
  - The counter is used for cool-down only.

## Structure
- Package `garage_pkg` holds:
  - `motor_ctrl_t` enum: STOP=2'b00, UP=2'b10, DOWN=2'b11.
  - `arb_state_t` enum: IDLE, RUN, COOLDOWN.
  - Default constants for the timeout and cool-down.
- Sub-module `garage_rr_pick`: a combinational round-robin picker taking the eligible vector and the pointer, returning a valid flag and an index.
- The top level holds the FSM, the counter, the latch registers and the fault flags.

## Test plan
- Reset, then `cmd[2]`=10 → `grant`=0100, `sel`=2 and `motor_ctrl`=10 one cycle later. Assert `done[2]` → `motor_ctrl`=00 next cycle; `busy` stays high for 16 cycles, then drops.
- Doors 0, 1 and 3 all request continuously, each acknowledging with `done` after 5 RUN cycles → grant order 0, 1, 3, 0, with cool-down between each.
- Owner holds 11 and never asserts `done` → `motor_ctrl`=11 for exactly 1000 cycles, then `fault[owner]`=1 and the door is skipped. Pulse `fault_clr` → the door is eligible again.
- Mid-RUN, the owner changes `cmd` from 10 to 11 → `motor_ctrl`=00 and COOLDOWN; the 11 request is granted only after the 16-cycle cool-down.
- `done` and timeout in the same cycle → no fault. Pulse `rst_n` low mid-RUN → outputs return to reset values immediately.
- Build without `GARAGE_ARB_TIMEOUT_EN` → no timeout after 2000 cycles and `fault` stays 0.
